// File: rtl/modulo_secded_pipeline_if.sv
// Valid/ready bus between the SECDED pipeline and its producer/consumer.
// Codewords flow in; corrected data and error flags flow out.
interface modulo_secded_pipeline_if #(
  parameter int DATA_W = 4
);
  localparam int P      = (DATA_W <= 4) ? 3 : ((DATA_W <= 11) ? 4 : 5);
  localparam int CODE_W = DATA_W + P + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] codeword_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic [4:0]        err_pos;
  logic              error_simple;
  logic              error_doble;

  modport master (
    output in_valid, codeword_in, out_ready,
    input  in_ready, out_valid, data_out, err_pos, error_simple, error_doble
  );

  modport slave (
    input  in_valid, codeword_in, out_ready,
    output in_ready, out_valid, data_out, err_pos, error_simple, error_doble
  );
endinterface

// File: rtl/modulo_secded_pipeline.sv
// Two-stage extended-Hamming SECDED decoder with saturating SEC/DED counters
// and a time-multiplexed two-digit 7-segment readout of the last result.
module modulo_secded_pipeline #(
  parameter int DATA_W   = 4,
  parameter int CNT_W    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  modulo_secded_pipeline_if.slave bus,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        cnt_sec,
  output logic [CNT_W-1:0]        cnt_ded,
  input  logic                    select_pos,
  output logic [6:0]              seg,
  output logic [1:0]              an
);
  localparam int P      = (DATA_W <= 4) ? 3 : ((DATA_W <= 11) ? 4 : 5);
  localparam int CODE_W = DATA_W + P + 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);

  function automatic logic [P-1:0] syndrome(input logic [CODE_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int j = 1; j < CODE_W; j++)
      for (int i = 0; i < P; i++)
        if (((j >> i) & 1) == 1) s[i] = s[i] ^ cw[j];
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int j = 1; j < CODE_W; j++)
      if ((j & (j - 1)) != 0) begin
        d[k] = cw[j];
        k++;
      end
    return d;
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;  4'hF: hex_glyph = 7'h71;
      default: hex_glyph = 7'h00;
    endcase
  endfunction

  logic              en_s, out_xfer_s;
  logic              s1_valid_r, s1_par_r;
  logic [P-1:0]      s1_syn_r;
  logic [CODE_W-1:0] s1_code_r, fixed_s;
  logic [4:0]        pos_s, err_pos_r, disp_pos_r;
  logic              sec_s, ded_s, sec_r, ded_r, out_valid_r;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  cnt_sec_r, cnt_ded_r;
  logic [7:0]        disp_byte_r;
  logic              disp_sec_r, disp_ded_r;
  logic [SCAN_W-1:0] scan_cnt_r;
  logic [1:0]        an_r;
  logic [6:0]        seg_r, left_s, right_s;

  assign en_s       = !out_valid_r || bus.out_ready;
  assign out_xfer_s = out_valid_r && bus.out_ready;

  // Stage 1: syndrome, overall parity and raw codeword
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_syn_r   <= '0;
      s1_par_r   <= 1'b0;
      s1_code_r  <= '0;
    end else if (en_s) begin
      s1_valid_r <= bus.in_valid;
      s1_syn_r   <= syndrome(bus.codeword_in);
      s1_par_r   <= ^bus.codeword_in;
      s1_code_r  <= bus.codeword_in;
    end
  end

  // Classify the error; a syndrome beyond the codeword with odd parity is uncorrectable
  always_comb begin
    fixed_s = s1_code_r;
    pos_s   = 5'd0;
    sec_s   = 1'b0;
    ded_s   = 1'b0;
    if (s1_par_r) begin
      if (int'(s1_syn_r) < CODE_W) begin
        fixed_s = s1_code_r ^ (CODE_ONE << s1_syn_r);
        pos_s   = 5'(s1_syn_r);
        sec_s   = 1'b1;
      end else begin
        ded_s = 1'b1;
      end
    end else if (s1_syn_r != '0) begin
      ded_s = 1'b1;
    end else begin
      ded_s = 1'b0;
    end
  end

  // Stage 2: registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      data_r      <= '0;
      err_pos_r   <= 5'd0;
      sec_r       <= 1'b0;
      ded_r       <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= s1_valid_r;
      data_r      <= extract_data(fixed_s);
      err_pos_r   <= pos_s;
      sec_r       <= sec_s;
      ded_r       <= ded_s;
    end
  end

  // Saturating error counters; clear takes priority over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_sec_r <= '0;
      cnt_ded_r <= '0;
    end else if (clr_cnt) begin
      cnt_sec_r <= '0;
      cnt_ded_r <= '0;
    end else begin
      if (out_xfer_s && sec_r && (cnt_sec_r != '1)) cnt_sec_r <= cnt_sec_r + CNT_W'(1);
      if (out_xfer_s && ded_r && (cnt_ded_r != '1)) cnt_ded_r <= cnt_ded_r + CNT_W'(1);
    end
  end

  // Display snapshot of the last accepted result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_byte_r <= 8'h00;
      disp_pos_r  <= 5'd0;
      disp_sec_r  <= 1'b0;
      disp_ded_r  <= 1'b0;
    end else if (out_xfer_s) begin
      disp_byte_r <= 8'(data_r);
      disp_pos_r  <= err_pos_r;
      disp_sec_r  <= sec_r;
      disp_ded_r  <= ded_r;
    end
  end

  // Glyphs for the two digits from the snapshot
  always_comb begin
    left_s  = hex_glyph(disp_byte_r[7:4]);
    right_s = hex_glyph(disp_byte_r[3:0]);
    if (select_pos) begin
      if (disp_ded_r) begin
        left_s  = 7'h79;
        right_s = 7'h79;
      end else if (!disp_sec_r) begin
        left_s  = 7'h40;
        right_s = 7'h40;
      end else begin
        left_s  = hex_glyph({3'b000, disp_pos_r[4]});
        right_s = hex_glyph(disp_pos_r[3:0]);
      end
    end else begin
      left_s  = hex_glyph(disp_byte_r[7:4]);
      right_s = hex_glyph(disp_byte_r[3:0]);
    end
  end

  // Digit scan: seg loads the incoming digit on the same edge an switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      an_r       <= 2'b10;
      seg_r      <= 7'h00;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      an_r       <= ~an_r;
      seg_r      <= an_r[1] ? right_s : left_s;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  assign bus.in_ready     = en_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.data_out     = data_r;
  assign bus.err_pos      = err_pos_r;
  assign bus.error_simple = sec_r;
  assign bus.error_doble  = ded_r;
  assign cnt_sec          = cnt_sec_r;
  assign cnt_ded          = cnt_ded_r;
  assign seg              = seg_r;
  assign an               = an_r;
endmodule
